// File: rtl/median_image_reader.sv
// Raster-scans the filtered-image memory and streams the pixels out packed 8 per byte, LSB first.
// Optional MEDIAN_READER_LAST_EN raises outLast on the byte that closes each image row.
module median_image_reader #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       readMedianImage,
    output logic [7:0] xAddressOut,
    output logic [7:0] yAddressOut,
    input  logic       medianDataIn,
    output logic [7:0] outData,
    output logic       outValid,
    input  logic       outReady,
    output logic       outLast
);

    // state    | meaning
    // IDLE     | waiting for start, addresses held at 0
    // READ     | one memory read per cycle
    // WAIT_OUT | output register still full after a byte's 8th read; reads paused
    // FLUSH    | all reads issued; drain pipeline and wait for the final byte's accept
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT_OUT,
        S_FLUSH
    } state_t;

    localparam logic [7:0] X_LAST = 8'(IMG_W - 1);
    localparam logic [7:0] Y_LAST = 8'(IMG_H - 1);

    state_t     r_state, w_next;
    logic [7:0] r_x, r_y;
    logic [2:0] r_bit_idx;
    logic       r_done;

    logic       r_pv     [RD_LAT];
    logic [2:0] r_pbit   [RD_LAT];
    logic       r_pframe [RD_LAT];

    logic [7:0] r_cap;
    logic       r_cap_full;
    logic       r_cap_frame;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic       r_out_frame;

    logic       w_issue;
    logic       w_frame_end;
    logic       w_ret_v;
    logic [2:0] w_ret_bit;
    logic       w_ret_byte;
    logic       w_out_free;
    logic       w_load_out;
    logic       w_byte_frame;
    logic [7:0] w_cap_next;

    assign w_issue      = (r_state == S_READ);
    assign w_frame_end  = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_ret_v      = r_pv[RD_LAT-1];
    assign w_ret_bit    = r_pbit[RD_LAT-1];
    assign w_ret_byte   = w_ret_v && (w_ret_bit == 3'd7);
    assign w_out_free   = !r_out_valid || outReady;
    // A held capture only exists while reads are paused, so it never collides with a returning byte.
    assign w_load_out   = (w_ret_byte || r_cap_full) && w_out_free;
    assign w_byte_frame = r_cap_full ? r_cap_frame : r_pframe[RD_LAT-1];

    always_comb begin
        w_cap_next = r_cap;
        if (w_ret_v) begin
            w_cap_next[w_ret_bit] = medianDataIn;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_READ;
            end
            S_READ: begin
                if (w_frame_end) begin
                    w_next = S_FLUSH;
                end else if ((r_bit_idx == 3'd7) && !w_out_free) begin
                    w_next = S_WAIT_OUT;
                end
            end
            S_WAIT_OUT: begin
                if (w_out_free) w_next = S_READ;
            end
            S_FLUSH: begin
                if (r_out_valid && r_out_frame && outReady) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_bit_idx <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_FLUSH) && (w_next == S_IDLE);
            if ((r_state == S_IDLE) && start) begin
                r_x       <= '0;
                r_y       <= '0;
                r_bit_idx <= '0;
            end else if (w_issue) begin
                r_bit_idx <= r_bit_idx + 3'd1;
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + 8'd1;
                end else begin
                    r_x <= r_x + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pv[i]     <= 1'b0;
                r_pbit[i]   <= '0;
                r_pframe[i] <= 1'b0;
            end
        end else begin
            r_pv[0]     <= w_issue;
            r_pbit[0]   <= r_bit_idx;
            r_pframe[0] <= w_frame_end;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i]     <= r_pv[i-1];
                r_pbit[i]   <= r_pbit[i-1];
                r_pframe[i] <= r_pframe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap       <= '0;
            r_cap_full  <= 1'b0;
            r_cap_frame <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_frame <= 1'b0;
        end else begin
            r_cap <= w_cap_next;
            if (w_ret_byte && !w_out_free) begin
                r_cap_full  <= 1'b1;
                r_cap_frame <= r_pframe[RD_LAT-1];
            end else if (w_load_out) begin
                r_cap_full <= 1'b0;
            end
            if (w_load_out) begin
                r_out_data  <= w_cap_next;
                r_out_valid <= 1'b1;
                r_out_frame <= w_byte_frame;
            end else if (outReady) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef MEDIAN_READER_LAST_EN
    logic r_prow [RD_LAT];
    logic r_cap_row;
    logic r_out_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_prow[i] <= 1'b0;
            end
            r_cap_row  <= 1'b0;
            r_out_last <= 1'b0;
        end else begin
            r_prow[0] <= (r_x == X_LAST);
            for (int i = 1; i < RD_LAT; i++) begin
                r_prow[i] <= r_prow[i-1];
            end
            if (w_ret_byte && !w_out_free) begin
                r_cap_row <= r_prow[RD_LAT-1];
            end
            if (w_load_out) begin
                r_out_last <= r_cap_full ? r_cap_row : r_prow[RD_LAT-1];
            end
        end
    end

    assign outLast = r_out_valid && r_out_last;
`else
    assign outLast = 1'b0;
`endif

    assign busy            = (r_state != S_IDLE);
    assign readMedianImage = busy;
    assign xAddressOut     = busy ? r_x : 8'd0;
    assign yAddressOut     = busy ? r_y : 8'd0;
    assign done            = r_done;
    assign outData         = r_out_data;
    assign outValid        = r_out_valid;

endmodule

// File: tb/tb_median_image_reader.sv
// Bench for median_image_reader: a 16x2/latency-1 instance and an 8x3/latency-4 instance,
// each fed by a behavioural memory, with expected bytes queued at start and compared on accept.
module tb_median_image_reader;

    logic clk;
    logic reset;

    logic       a_start, a_busy, a_done, a_rd, a_mem, a_valid, a_ready, a_last;
    logic [7:0] a_x, a_y, a_data;
    logic       b_start, b_busy, b_done, b_rd, b_valid, b_ready, b_last;
    logic [7:0] b_x, b_y, b_data;
    logic       b_d [4];

    int a_mode, b_mode;
    int cyc, start_cyc;
    int n_tests, n_fail;

    logic [8:0] exp_q[$];
    logic [8:0] recv_q[$];
    int         recv_cyc[$];

    int         got, wraps, first_lat, done_early;
    bit         stable;
    logic [7:0] hold_x, hold_y;

    median_image_reader #(.IMG_W(16), .IMG_H(2), .RD_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
        .readMedianImage(a_rd), .xAddressOut(a_x), .yAddressOut(a_y),
        .medianDataIn(a_mem), .outData(a_data), .outValid(a_valid),
        .outReady(a_ready), .outLast(a_last)
    );

    median_image_reader #(.IMG_W(8), .IMG_H(3), .RD_LAT(4)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
        .readMedianImage(b_rd), .xAddressOut(b_x), .yAddressOut(b_y),
        .medianDataIn(b_d[3]), .outData(b_data), .outValid(b_valid),
        .outReady(b_ready), .outLast(b_last)
    );

    function automatic logic pix(input int mode, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] h;
        h = (x * 8'd37) ^ (y * 8'd91) ^ 8'h5c;
        case (mode)
            0:       return x[0];
            1:       return h[3] ^ h[6];
            default: return 1'b1;
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        a_mem  <= pix(a_mode, a_x, a_y);
        b_d[0] <= pix(b_mode, b_x, b_y);
        b_d[1] <= b_d[0];
        b_d[2] <= b_d[1];
        b_d[3] <= b_d[2];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input int w, input int h, input int mode);
        logic [7:0] b;
        logic       l;
        for (int y = 0; y < h; y++) begin
            for (int xb = 0; xb < w / 8; xb++) begin
                for (int k = 0; k < 8; k++) b[k] = pix(mode, 8'(xb * 8 + k), 8'(y));
`ifdef MEDIAN_READER_LAST_EN
                l = (xb == w / 8 - 1);
`else
                l = 1'b0;
`endif
                exp_q.push_back({l, b});
            end
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        recv_q.delete();
        recv_cyc.delete();
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 0) a_start = 1'b1; else b_start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        if (sel == 0) a_start = 1'b0; else b_start = 1'b0;
    endtask

    // Drives outReady and records accepted bytes; comparisons happen in the calling test.
    task automatic collect(input int sel, input int n_bytes, input int max_cyc, input int hold_len,
                           input bit rnd, input int pulse_at, input int img_h);
        int         t, hc;
        bit         seen;
        logic       v, l, bz, dn, rd;
        logic [7:0] d, x, y, held, prev_x;
        got = 0; wraps = 0; first_lat = -1; done_early = 0; stable = 1'b1;
        t = 0; hc = 0; seen = 1'b0; held = '0; prev_x = '0;
        while (got < n_bytes && t < max_cyc) begin
            @(negedge clk);
            t++;
            if (sel == 0) begin
                v = a_valid; d = a_data; l = a_last; x = a_x; y = a_y; bz = a_busy; dn = a_done;
            end else begin
                v = b_valid; d = b_data; l = b_last; x = b_x; y = b_y; bz = b_busy; dn = b_done;
            end
            if (dn) done_early++;
            if (bz && prev_x == 8'd7 && x == 8'd0 && int'(y) < img_h) wraps++;
            prev_x = x;
            if (pulse_at > 0) begin
                if (sel == 0) a_start = (t == pulse_at); else b_start = (t == pulse_at);
            end
            if (v && !seen) begin
                seen = 1'b1;
                first_lat = cyc - start_cyc;
                held = d;
            end
            if (seen && hc < hold_len) begin
                rd = 1'b0;
                if (!v || d !== held) stable = 1'b0;
                hc++;
                if (hc == hold_len) begin
                    hold_x = x;
                    hold_y = y;
                end
            end else begin
                rd = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (sel == 0) a_ready = rd; else b_ready = rd;
            if (v && rd) begin
                recv_q.push_back({l, d});
                recv_cyc.push_back(cyc);
                got++;
            end
        end
        if (sel == 0) a_start = 1'b0; else b_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({a_busy, a_done, a_rd, a_x, a_y, a_data, a_valid, a_last} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_a: outputs %h, expected all 0",
                     {a_busy, a_done, a_rd, a_x, a_y, a_data, a_valid, a_last});
        end
        n_tests++;
        if ({b_busy, b_done, b_rd, b_x, b_y, b_data, b_valid, b_last} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_b: outputs %h, expected all 0",
                     {b_busy, b_done, b_rd, b_x, b_y, b_data, b_valid, b_last});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [8:0] e, r;
        clear_queues();
        a_mode = 0;
        push_frame(16, 2, 0);
        pulse_start(0);
        collect(0, 4, 200, 0, 1'b0, 0, 2);
        n_tests++;
        if (got !== 4) begin n_fail++; $display("FAIL basic_count: got %0d bytes, expected 4", got); end
        n_tests++;
        if (first_lat !== 10) begin n_fail++; $display("FAIL basic_latency: first byte at %0d, expected 10", first_lat); end
        for (int i = 1; i < recv_cyc.size(); i++) begin
            n_tests++;
            if (recv_cyc[i] - recv_cyc[i-1] !== 8) begin
                n_fail++;
                $display("FAIL basic_interval: byte %0d gap %0d, expected 8", i, recv_cyc[i] - recv_cyc[i-1]);
            end
        end
        while (exp_q.size() > 0 && recv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = recv_q.pop_front();
            n_tests++;
            if (r !== e) begin n_fail++; $display("FAIL basic_byte: got %h, expected %h", r, e); end
        end
        n_tests++;
        if (done_early !== 0) begin n_fail++; $display("FAIL basic_early_done: %0d, expected 0", done_early); end
        @(negedge clk);
        n_tests++;
        if ({a_done, a_busy} !== 2'b10) begin n_fail++; $display("FAIL basic_done: done/busy %b, expected 10", {a_done, a_busy}); end
        @(negedge clk);
        n_tests++;
        if (a_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: done %b, expected 0", a_done); end
    endtask

    task automatic test_backpressure();
        logic [8:0] e, r;
        clear_queues();
        a_mode = 1;
        push_frame(16, 2, 1);
        pulse_start(0);
        collect(0, 4, 300, 20, 1'b0, 0, 2);
        n_tests++;
        if (got !== 4) begin n_fail++; $display("FAIL bp_count: got %0d bytes, expected 4", got); end
        n_tests++;
        if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_hold: output changed while stalled, expected steady"); end
        // Two bytes are read before the stall, so the paused address is pixel 16.
        n_tests++;
        if ({hold_x, hold_y} !== {8'(16 % 16), 8'(16 / 16)}) begin
            n_fail++;
            $display("FAIL bp_stall_addr: (%0d,%0d), expected (0,1)", hold_x, hold_y);
        end
        while (exp_q.size() > 0 && recv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = recv_q.pop_front();
            n_tests++;
            if (r !== e) begin n_fail++; $display("FAIL bp_byte: got %h, expected %h", r, e); end
        end
        @(negedge clk);
        n_tests++;
        if ({a_done, a_busy} !== 2'b10) begin n_fail++; $display("FAIL bp_done: done/busy %b, expected 10", {a_done, a_busy}); end
    endtask

    task automatic test_max_latency();
        logic [8:0] e, r;
        clear_queues();
        b_mode = 2;
        push_frame(8, 3, 2);
        pulse_start(1);
        collect(1, 3, 200, 0, 1'b0, 0, 3);
        n_tests++;
        if (got !== 3) begin n_fail++; $display("FAIL lat4_count: got %0d bytes, expected 3", got); end
        n_tests++;
        if (first_lat !== 13) begin n_fail++; $display("FAIL lat4_latency: first byte at %0d, expected 13", first_lat); end
        n_tests++;
        if (wraps !== 2) begin n_fail++; $display("FAIL lat4_wraps: x wrapped %0d times, expected 2", wraps); end
        while (exp_q.size() > 0 && recv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = recv_q.pop_front();
            n_tests++;
            if (r !== e) begin n_fail++; $display("FAIL lat4_byte: got %h, expected %h", r, e); end
        end
        @(negedge clk);
        n_tests++;
        if ({b_done, b_busy} !== 2'b10) begin n_fail++; $display("FAIL lat4_done: done/busy %b, expected 10", {b_done, b_busy}); end
        // Same instance with a mixed pattern and random backpressure.
        clear_queues();
        b_mode = 1;
        push_frame(8, 3, 1);
        pulse_start(1);
        collect(1, 3, 400, 0, 1'b1, 0, 3);
        n_tests++;
        if (got !== 3) begin n_fail++; $display("FAIL lat4_rnd_count: got %0d bytes, expected 3", got); end
        while (exp_q.size() > 0 && recv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = recv_q.pop_front();
            n_tests++;
            if (r !== e) begin n_fail++; $display("FAIL lat4_rnd_byte: got %h, expected %h", r, e); end
        end
        @(negedge clk);
        n_tests++;
        if (b_done !== 1'b1) begin n_fail++; $display("FAIL lat4_rnd_done: done %b, expected 1", b_done); end
    endtask

    task automatic test_restart();
        logic [8:0] e, r;
        int         extra;
        clear_queues();
        a_mode = 1;
        push_frame(16, 2, 1);
        pulse_start(0);
        collect(0, 4, 300, 0, 1'b0, 15, 2);
        n_tests++;
        if (got !== 4) begin n_fail++; $display("FAIL restart_count: got %0d bytes, expected 4", got); end
        while (exp_q.size() > 0 && recv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = recv_q.pop_front();
            n_tests++;
            if (r !== e) begin n_fail++; $display("FAIL restart_byte: got %h, expected %h", r, e); end
        end
        @(negedge clk);
        n_tests++;
        if (a_done !== 1'b1) begin n_fail++; $display("FAIL restart_done: done %b, expected 1", a_done); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_valid || a_busy) extra++;
        end
        n_tests++;
        if (extra !== 0) begin n_fail++; $display("FAIL restart_extra: %0d active cycles after done, expected 0", extra); end

        pulse_start(0);
        repeat (12) @(negedge clk);
        n_tests++;
        if (a_busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy: busy %b, expected 1", a_busy); end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({a_busy, a_done, a_rd, a_x, a_y, a_data, a_valid, a_last} !== 29'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: outputs %h, expected all 0",
                     {a_busy, a_done, a_rd, a_x, a_y, a_data, a_valid, a_last});
        end
        reset = 1'b0;

        clear_queues();
        push_frame(16, 2, 1);
        pulse_start(0);
        n_tests++;
        if ({a_busy, a_x, a_y} !== {1'b1, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL after_reset_addr: busy %b addr (%0d,%0d), expected busy 1 at (0,0)", a_busy, a_x, a_y);
        end
        collect(0, 4, 300, 0, 1'b0, 0, 2);
        n_tests++;
        if (got !== 4) begin n_fail++; $display("FAIL after_reset_count: got %0d bytes, expected 4", got); end
        while (exp_q.size() > 0 && recv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = recv_q.pop_front();
            n_tests++;
            if (r !== e) begin n_fail++; $display("FAIL after_reset_byte: got %h, expected %h", r, e); end
        end
        @(negedge clk);
    endtask

    task automatic test_row_marker();
        logic [8:0] e, r;
        clear_queues();
        a_mode = 1;
        push_frame(16, 2, 1);
        pulse_start(0);
        collect(0, 4, 400, 0, 1'b1, 0, 2);
        n_tests++;
        if (got !== 4) begin n_fail++; $display("FAIL row_count: got %0d bytes, expected 4", got); end
        while (exp_q.size() > 0 && recv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = recv_q.pop_front();
            n_tests++;
            if (r[8] !== e[8]) begin n_fail++; $display("FAIL row_last: outLast %b, expected %b", r[8], e[8]); end
            n_tests++;
            if (r[7:0] !== e[7:0]) begin n_fail++; $display("FAIL row_byte: got %h, expected %h", r[7:0], e[7:0]); end
        end
        @(negedge clk);
        n_tests++;
        if (a_done !== 1'b1) begin n_fail++; $display("FAIL row_done: done %b, expected 1", a_done); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; start_cyc = 0;
        a_mode = 0; b_mode = 2;
        a_start = 1'b0; a_ready = 1'b1;
        b_start = 1'b0; b_ready = 1'b1;
        hold_x = '0; hold_y = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_max_latency();
        test_restart();
        test_row_marker();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
